// File: rtl/dla_aux_pool_window_sequencer.sv
// Pool window sequencer: walks the padded input plane of a tile in raster order
// and emits per-position padding flags, pad masks, stride-valid and line-buffer control.
module dla_aux_pool_window_sequencer #(
    parameter int MAX_WINDOW_HEIGHT = 8,
    parameter int MAX_WINDOW_WIDTH  = 8,
    parameter int MAX_STRIDE        = 8,
    parameter int MAX_TILE_HEIGHT   = 64,
    parameter int MAX_TILE_WIDTH    = 64,
    parameter int MAX_PAD           = 7,
    parameter int MAX_PLANES        = 256,
    parameter int WHB = $clog2(MAX_WINDOW_HEIGHT + 1),
    parameter int WWB = $clog2(MAX_WINDOW_WIDTH + 1),
    parameter int SB  = $clog2(MAX_STRIDE + 1),
    parameter int THB = $clog2(MAX_TILE_HEIGHT + 1),
    parameter int TWB = $clog2(MAX_TILE_WIDTH + 1),
    parameter int PB  = $clog2(MAX_PAD + 1),
    parameter int PLB = $clog2(MAX_PLANES + 1)
) (
    input  logic                         clk,
    input  logic                         i_areset,
    input  logic                         i_config_valid,
    output logic                         o_config_ready,
    input  logic [WHB-1:0]               i_window_height,
    input  logic [WWB-1:0]               i_window_width,
    input  logic [SB-1:0]                i_stride_vertical,
    input  logic [SB-1:0]                i_stride_horizontal,
    input  logic [THB-1:0]               i_tile_height,
    input  logic [TWB-1:0]               i_tile_width,
    input  logic [PB-1:0]                i_pad_top,
    input  logic [PB-1:0]                i_pad_bottom,
    input  logic [PB-1:0]                i_pad_left,
    input  logic [PB-1:0]                i_pad_right,
    input  logic [PLB-1:0]               i_planes,
    input  logic [1:0]                   i_padding_mode,
    input  logic                         i_padding_ignore,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_is_padding_zone_vert,
    output logic                         o_is_padding_zone_horiz,
    output logic [MAX_WINDOW_HEIGHT-1:0] o_en_pad_zero_vert,
    output logic [MAX_WINDOW_HEIGHT-1:0] o_en_pad_nan_vert,
    output logic [MAX_WINDOW_WIDTH-1:0]  o_en_pad_zero_horiz,
    output logic [MAX_WINDOW_WIDTH-1:0]  o_en_pad_nan_horiz,
    output logic                         o_stride_valid,
    output logic                         o_line_buff_wait_fill,
    output logic                         o_line_buff_flush,
    output logic                         o_config_error
);
    // Common width for all position arithmetic; holds the largest padded extent.
    localparam int CW = ((THB > TWB) ? THB : TWB) + 2;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
    state_t state;

    logic [WHB-1:0] wh_q;
    logic [WWB-1:0] ww_q;
    logic [SB-1:0]  sv_q, sh_q;
    logic [THB-1:0] th_q;
    logic [TWB-1:0] tw_q;
    logic [PB-1:0]  pt_q, pb_q, pl_q, pr_q;
    logic [PLB-1:0] planes_q, plane;
    logic [1:0]     mode_q;
    logic           ignore_q;
    logic [CW-1:0]  row, col, vph, hph;

    // In IDLE the incoming config drives the first position's flags, so they are
    // registered on the same edge the config is accepted.
    logic          sel_in;
    logic [CW-1:0] wh_c, ww_c, sv_c, sh_c, th_c, tw_c, pt_c, pb_c, pl_c, pr_c, ph_c, pw_c;
    logic [1:0]    mode_c;
    logic          ign_c;

    assign sel_in = (state == IDLE);
    assign wh_c   = sel_in ? CW'(i_window_height)     : CW'(wh_q);
    assign ww_c   = sel_in ? CW'(i_window_width)      : CW'(ww_q);
    assign sv_c   = sel_in ? CW'(i_stride_vertical)   : CW'(sv_q);
    assign sh_c   = sel_in ? CW'(i_stride_horizontal) : CW'(sh_q);
    assign th_c   = sel_in ? CW'(i_tile_height)       : CW'(th_q);
    assign tw_c   = sel_in ? CW'(i_tile_width)        : CW'(tw_q);
    assign pt_c   = sel_in ? CW'(i_pad_top)           : CW'(pt_q);
    assign pb_c   = sel_in ? CW'(i_pad_bottom)        : CW'(pb_q);
    assign pl_c   = sel_in ? CW'(i_pad_left)          : CW'(pl_q);
    assign pr_c   = sel_in ? CW'(i_pad_right)         : CW'(pr_q);
    assign mode_c = sel_in ? i_padding_mode           : mode_q;
    assign ign_c  = sel_in ? i_padding_ignore         : ignore_q;
    assign ph_c   = th_c + pt_c + pb_c;
    assign pw_c   = tw_c + pl_c + pr_c;

    logic cfg_err, last, more, load;
    assign cfg_err = (wh_c == '0) || (ww_c == '0) || (sv_c == '0) || (sh_c == '0) ||
                     (th_c == '0) || (tw_c == '0) || (i_planes == '0) ||
                     (wh_c > ph_c) || (ww_c > pw_c);
    assign last = (row == ph_c - ONE) && (col == pw_c - ONE);
    assign more = (plane + PLB'(1)) < planes_q;
    assign load = (state == IDLE && i_config_valid && !cfg_err) ||
                  (state == SCAN && i_ready && !last) ||
                  (state == FLUSH && more);

    logic [CW-1:0] nrow, ncol, nvph, nhph, vr, hr;
    logic          f_pzv, f_pzh, f_wf, f_sv;
    logic [MAX_WINDOW_HEIGHT-1:0] vm;
    logic [MAX_WINDOW_WIDTH-1:0]  hm;

    always_comb begin
        nrow = '0;
        ncol = '0;
        nvph = '0;
        nhph = '0;
        vr   = '0;
        hr   = '0;
        vm   = '0;
        hm   = '0;
        if (state == SCAN) begin
            nrow = row;
            ncol = col + ONE;
            nvph = vph;
            if (col == pw_c - ONE) begin
                ncol = '0;
                nrow = row + ONE;
                // Phase restarts at the first row that can complete a window.
                if (nrow == wh_c - ONE || vph + ONE == sv_c) nvph = '0;
                else                                         nvph = vph + ONE;
            end
            if (ncol == ww_c - ONE || hph + ONE == sh_c) nhph = '0;
            else                                         nhph = hph + ONE;
        end
        f_pzv = (nrow < pt_c) || (nrow >= pt_c + th_c);
        f_pzh = (ncol < pl_c) || (ncol >= pl_c + tw_c);
        f_wf  = nrow < wh_c - ONE;
        f_sv  = (nrow >= wh_c - ONE) && (ncol >= ww_c - ONE) && (nvph == '0) && (nhph == '0);
        for (int k = 0; k < MAX_WINDOW_HEIGHT; k++) begin
            vr    = nrow + CW'(k) + ONE - wh_c;
            vm[k] = (CW'(k) < wh_c) && ((vr < pt_c) || (vr >= pt_c + th_c));
        end
        for (int k = 0; k < MAX_WINDOW_WIDTH; k++) begin
            hr    = ncol + CW'(k) + ONE - ww_c;
            hm[k] = (CW'(k) < ww_c) && ((hr < pl_c) || (hr >= pl_c + tw_c));
        end
        if (!f_sv || ign_c) begin
            vm = '0;
            hm = '0;
        end
    end

    always_ff @(posedge clk or posedge i_areset) begin
        if (i_areset) begin
            state                   <= IDLE;
            o_config_ready          <= 1'b1;
            o_config_error          <= 1'b0;
            o_valid                 <= 1'b0;
            o_line_buff_flush       <= 1'b0;
            o_is_padding_zone_vert  <= 1'b0;
            o_is_padding_zone_horiz <= 1'b0;
            o_line_buff_wait_fill   <= 1'b0;
            o_stride_valid          <= 1'b0;
            o_en_pad_zero_vert      <= '0;
            o_en_pad_nan_vert       <= '0;
            o_en_pad_zero_horiz     <= '0;
            o_en_pad_nan_horiz      <= '0;
            {wh_q, ww_q, sv_q, sh_q, th_q, tw_q} <= '0;
            {pt_q, pb_q, pl_q, pr_q, planes_q, plane, mode_q, ignore_q} <= '0;
            {row, col, vph, hph} <= '0;
        end else begin
            o_line_buff_flush <= 1'b0;
            if (load) begin
                row                     <= nrow;
                col                     <= ncol;
                vph                     <= nvph;
                hph                     <= nhph;
                o_valid                 <= 1'b1;
                o_is_padding_zone_vert  <= f_pzv;
                o_is_padding_zone_horiz <= f_pzh;
                o_line_buff_wait_fill   <= f_wf;
                o_stride_valid          <= f_sv;
                o_en_pad_zero_vert      <= (mode_c != 2'd1) ? vm : '0;
                o_en_pad_nan_vert       <= (mode_c == 2'd1) ? vm : '0;
                o_en_pad_zero_horiz     <= (mode_c != 2'd1) ? hm : '0;
                o_en_pad_nan_horiz      <= (mode_c == 2'd1) ? hm : '0;
            end
            case (state)
                IDLE: if (i_config_valid) begin
                    wh_q     <= i_window_height;
                    ww_q     <= i_window_width;
                    sv_q     <= i_stride_vertical;
                    sh_q     <= i_stride_horizontal;
                    th_q     <= i_tile_height;
                    tw_q     <= i_tile_width;
                    pt_q     <= i_pad_top;
                    pb_q     <= i_pad_bottom;
                    pl_q     <= i_pad_left;
                    pr_q     <= i_pad_right;
                    planes_q <= i_planes;
                    mode_q   <= i_padding_mode;
                    ignore_q <= i_padding_ignore;
                    o_config_error <= cfg_err;
                    if (!cfg_err) begin
                        state          <= SCAN;
                        o_config_ready <= 1'b0;
                        plane          <= '0;
                    end
                end
                SCAN: if (i_ready && last) begin
                    state                   <= FLUSH;
                    o_valid                 <= 1'b0;
                    o_line_buff_flush       <= 1'b1;
                    o_is_padding_zone_vert  <= 1'b0;
                    o_is_padding_zone_horiz <= 1'b0;
                    o_line_buff_wait_fill   <= 1'b0;
                    o_stride_valid          <= 1'b0;
                    o_en_pad_zero_vert      <= '0;
                    o_en_pad_nan_vert       <= '0;
                    o_en_pad_zero_horiz     <= '0;
                    o_en_pad_nan_horiz      <= '0;
                end
                FLUSH: if (more) begin
                    plane <= plane + PLB'(1);
                    state <= SCAN;
                end else begin
                    state          <= IDLE;
                    o_config_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dla_aux_pool_window_sequencer.md
Name: dla_aux_pool_window_sequencer

Overview:
- Next-generation pool control core. Takes one pooling configuration and walks the padded input plane of a tile in raster order, one position per accepted beat.
- For each position it produces the per-lane control: padding-zone flags, per-window-row and per-window-column NaN/zero pad masks, stride-valid, line-buffer wait-fill, and line-buffer flush.
- Extends the previous control with asymmetric padding (top, bottom, left and right set independently), multi-plane repetition and explicit config error reporting.
- Sits between the aux pool config decoder and the pool lanes.

Parameters:
MAX_WINDOW_HEIGHT, 8, largest window height; width of vertical masks
MAX_WINDOW_WIDTH, 8, largest window width; width of horizontal masks
MAX_STRIDE, 8, largest stride in either axis
MAX_TILE_HEIGHT, 64, largest unpadded tile height
MAX_TILE_WIDTH, 64, largest unpadded tile width
MAX_PAD, 7, largest padding on any single side
MAX_PLANES, 256, largest plane repeat count
Derived field widths: WHB=$clog2(MAX_WINDOW_HEIGHT+1), WWB, SB, THB, TWB, PB, PLB, each computed the same way.

Ports:
clk  in  1  clock
i_areset  in  1  asynchronous reset, active-high
i_config_valid  in  1  config offered
o_config_ready  out  1  config accepted this cycle when both valid and ready
i_window_height / i_window_width  in  WHB / WWB  window size
i_stride_vertical / i_stride_horizontal  in  SB each  strides
i_tile_height / i_tile_width  in  THB / TWB  unpadded tile size
i_pad_top / i_pad_bottom / i_pad_left / i_pad_right  in  PB each  padding per side
i_planes  in  PLB  number of plane scans
i_padding_mode  in  2  0 = zero, 1 = NaN, 2/3 = reserved (treated as zero)
i_padding_ignore  in  1  forces all masks to 0
o_valid  out  1  current position valid
i_ready  in  1  lane not stalled
o_is_padding_zone_vert / o_is_padding_zone_horiz  out  1 each  current row/column lies in padding
o_en_pad_zero_vert / o_en_pad_nan_vert  out  MAX_WINDOW_HEIGHT each  per-window-row masks
o_en_pad_zero_horiz / o_en_pad_nan_horiz  out  MAX_WINDOW_WIDTH each  per-window-column masks
o_stride_valid  out  1  window ending at this position is an output
o_line_buff_wait_fill  out  1  row < window_height-1
o_line_buff_flush  out  1  end-of-plane pulse
o_config_error  out  1  sticky flag for the last accepted config

Behaviour:
- All outputs are registered. Reset drives the FSM to IDLE, all counters to 0 and every output to 0, except o_config_ready=1. Reset is honoured mid-scan; no flush pulse is produced on reset.
- FSM states: IDLE, SCAN, FLUSH.
- IDLE: o_config_ready=1. On valid & ready:
  - latch all config fields.
  - Any of window, stride, tile or planes equal to 0, or window > padded extent in either axis: set o_config_error=1 and stay in IDLE.
  - Otherwise clear o_config_error and enter SCAN with row=col=plane=0.
- SCAN: o_valid=1, o_config_ready=0.
  - Padded extents: PH = tile_height+pad_top+pad_bottom; PW = tile_width+pad_left+pad_right.
  - On o_valid & i_ready, col increments. At PW-1, col wraps to 0 and row increments. At row PH-1 and col PW-1, go to FLUSH.
  - With i_ready=0, every output and counter holds.
- FLUSH: exactly one cycle with o_line_buff_flush=1 and o_valid=0. Then plane increments. If plane+1 < planes, return to SCAN with row=col=0; otherwise go to IDLE. FLUSH does not wait on i_ready.
- Output flags in SCAN:
  - o_is_padding_zone_vert = row < pad_top or row >= pad_top+tile_height; the horizontal flag is defined the same way on col.
  - o_line_buff_wait_fill = row < window_height-1.
- Stride phase counters replace modulo:
  - vphase resets to 0 at the first row with row = window_height-1, increments per row and wraps at stride_vertical.
  - hphase does the same per column, restarting each row.
  - o_stride_valid = row >= WH-1 and col >= WW-1 and vphase==0 and hphase==0.
- Masks:
  - Vertical bit k (k < window_height) = padded row (row-(WH-1)+k) is a padding row. Bit 0 is the oldest row.
  - Horizontal masks are defined the same way on columns.
  - Bits >= window size are 0. All masks are 0 when o_stride_valid=0 or padding_ignore=1.
  - The zero masks carry the bits when mode != 1; the NaN masks carry them when mode == 1. The two masks are never both set for the same bit.
- Arithmetic: PH and PW are held at THB+1 and TWB+1 bits; no wrap is permitted.

Test Plan:
- Window 3x3, stride 1, tile 4x4, pad 1 on all sides, planes 1, mode 0, i_ready=1 -> 36 valid beats and 16 stride_valid. First stride_valid is on beat 14 (row 2, col 2) with zero_vert=001, zero_horiz=001 and NaN masks 0. Then one flush pulse, then back to IDLE.
- Window 2x2, stride 2, tile 4x4, no padding -> stride_valid only at (1,1), (1,3), (3,1), (3,3); masks all 0; wait_fill=1 on row 0 only.
- Mode 1, pad_bottom=2, other pads 0, window 3x3, stride 1, tile 3x3 -> at (4,2) nan_vert=110 and zero_vert=0. Repeating with padding_ignore=1 gives all masks 0.
- i_ready held low 5 cycles at (2,3) of the first case -> outputs frozen; resumes at (2,3) then (2,4); total beats still 36.
- planes=3, tile 2x2, window 1x1, stride 1 -> 3×4 beats, exactly 3 flush pulses each followed by row=col=0. Asserting i_areset during plane 2 -> all outputs 0 next edge, o_config_ready=1.
- Config with stride_vertical=0 -> accepted, o_config_error=1, o_valid stays 0. The next valid config clears o_config_error.
